// File: rtl/irq_edge_ctrl.sv
// Avalon-MM interrupt controller: samples up to 8 request lines as level or rising edge,
// holds pending/mask/mode state, reports the highest-priority source and a combined irq.
module irq_edge_ctrl #(
  parameter int          NUM_SRC    = 8,
  parameter logic [7:0]  MODE_RESET = 8'h00
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq
);

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_MODE   = 3'd2;
  localparam logic [2:0] ADDR_RAW    = 3'd3;
  localparam logic [2:0] ADDR_VECTOR = 3'd4;
  localparam logic [2:0] ADDR_COUNT  = 3'd5;

  logic [NUM_SRC-1:0] irq_s, irq_d;
  logic [NUM_SRC-1:0] pending, mask, mode;
  logic [NUM_SRC-1:0] rise, clr, active;
  logic [15:0]        count;
  logic [15:0]        rd_mux;
  logic [2:0]         src;
  logic               valid;
  logic               wr;

  // Upper write-data bits only matter when NUM_SRC < 8; keep them visibly consumed.
  logic unused_wdata;
  assign unused_wdata = ^writedata[15:NUM_SRC];

  assign wr     = chipselect & ~write_n;
  assign rise   = irq_s & ~irq_d;
  assign clr    = (wr && address == ADDR_STATUS) ? writedata[NUM_SRC-1:0] : '0;
  assign active = pending & mask;
  assign valid  = |active;
  assign irq    = valid;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    src = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) src = 3'(i);
    end
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (address)
      ADDR_STATUS: rd_mux = 16'(pending);
      ADDR_MASK:   rd_mux = 16'(mask);
      ADDR_MODE:   rd_mux = 16'(mode);
      ADDR_RAW:    rd_mux = 16'(irq_s);
      ADDR_VECTOR: rd_mux = {valid, 12'h000, src};
      ADDR_COUNT:  rd_mux = count;
      default:     rd_mux = 16'h0000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_s    <= '0;
      irq_d    <= '0;
      pending  <= '0;
      mask     <= '0;
      mode     <= MODE_RESET[NUM_SRC-1:0];
      count    <= 16'h0000;
      readdata <= 16'h0000;
    end else begin
      irq_s    <= irq_in;
      irq_d    <= irq_s;
      readdata <= rd_mux;
      // Edge sources: set beats clear. Level sources simply follow the synchronised line.
      pending  <= (mode & ((pending & ~clr) | rise)) | (~mode & irq_s);
      if (wr && address == ADDR_MASK) mask <= writedata[NUM_SRC-1:0];
      if (wr && address == ADDR_MODE) mode <= writedata[NUM_SRC-1:0];
      if (wr && address == ADDR_COUNT)
        count <= 16'h0000;
      else if (|(rise & mask) && count != 16'hFFFF)
        count <= count + 16'd1;
    end
  end

endmodule

// File: tb/tb_irq_edge_ctrl.sv
// Self-checking bench for irq_edge_ctrl: register reads go through an expected-value queue,
// irq behaviour is checked inline per scenario task.
module tb_irq_edge_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [7:0]  irq_in;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];

  irq_edge_ctrl #(.NUM_SRC(8), .MODE_RESET(8'h00)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Expected value is queued with the request and compared when readdata is produced.
  task automatic bus_read(input logic [2:0] a, input logic [15:0] exp, input string nm);
    logic [15:0] e;
    string       n;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    n_checks++;
    if (readdata !== e) begin
      n_fail++;
      $display("FAIL %s: readdata=%h expected=%h", n, readdata, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; irq_in = 8'h01; address = 3'd0; chipselect = 1'b0;
    write_n = 1'b1; writedata = 16'h0000;
    idle(3);
    n_checks++;
    if (irq !== 1'b0 || readdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: irq=%b readdata=%h expected irq=0 readdata=0000", irq, readdata);
    end
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (irq !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_masked_irq cycle %0d: irq=%b expected=0", i, irq);
      end
    end
    bus_read(3'd2, 16'h0000, "mode_reset_value");
    bus_read(3'd3, 16'h0001, "raw_read");
    bus_write(3'd1, 16'h0001);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_write_irq: irq=%b expected=1", irq);
    end
    bus_read(3'd0, 16'h0001, "status_after_mask");
    bus_read(3'd5, 16'h0000, "count_unmasked_rise");
    @(negedge clk); irq_in = 8'h00;
    idle(3);
  endtask

  task automatic test_edge_pulse;
    bus_write(3'd2, 16'h0001);
    bus_write(3'd1, 16'h0001);
    bus_write(3'd5, 16'h0000);
    @(negedge clk); irq_in = 8'h01;
    @(posedge clk); #1;
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_latency_n: irq=%b expected=0", irq);
    end
    @(negedge clk); irq_in = 8'h00;
    @(posedge clk); #1;
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_latency_n1: irq=%b expected=1", irq);
    end
    idle(3);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_held: irq=%b expected=1", irq);
    end
    bus_write(3'd0, 16'h0001);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_w1c: irq=%b expected=0", irq);
    end
    bus_read(3'd5, 16'h0001, "count_one_pulse");
  endtask

  task automatic test_level;
    bus_write(3'd2, 16'h0000);
    bus_write(3'd1, 16'h0008);
    @(negedge clk); irq_in = 8'h08;
    idle(3);
    bus_write(3'd0, 16'h0008);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL level_w1c_ignored: irq=%b expected=1", irq);
    end
    bus_read(3'd0, 16'h0008, "level_status");
    @(negedge clk); irq_in = 8'h00;
    @(posedge clk); #1;
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL level_fall_n: irq=%b expected=1", irq);
    end
    @(posedge clk); #1;
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL level_fall_n1: irq=%b expected=0", irq);
    end
  endtask

  task automatic test_vector;
    bus_write(3'd2, 16'h0024);
    bus_write(3'd1, 16'h0024);
    @(negedge clk); irq_in = 8'h24;
    @(negedge clk); irq_in = 8'h00;
    idle(3);
    bus_read(3'd4, 16'h8002, "vector_src2");
    bus_write(3'd0, 16'h0004);
    bus_read(3'd4, 16'h8005, "vector_src5");
    bus_read(3'd0, 16'h0020, "status_src5");
    bus_write(3'd0, 16'h0020);
    bus_read(3'd4, 16'h0000, "vector_none");
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL vector_irq_low: irq=%b expected=0", irq);
    end
  endtask

  task automatic test_set_wins;
    bus_write(3'd2, 16'h0002);
    bus_write(3'd1, 16'h0002);
    @(negedge clk); irq_in = 8'h02;
    @(posedge clk);
    // Write lands on the edge where rise[1] is asserted.
    bus_write(3'd0, 16'h0002);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins_irq: irq=%b expected=1", irq);
    end
    bus_read(3'd0, 16'h0002, "set_wins_status");
    @(negedge clk); irq_in = 8'h00;
    bus_write(3'd0, 16'h0002);
    bus_read(3'd0, 16'h0000, "set_wins_cleared");
  endtask

  // Alternating between two sources yields one masked rise every clock.
  task automatic rise_burst(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      irq_in = (k % 2 == 0) ? 8'h01 : 8'h02;
    end
    @(negedge clk); irq_in = 8'h00;
    idle(2);
  endtask

  task automatic test_count;
    bus_write(3'd1, 16'h0003);
    idle(2);
    bus_write(3'd5, 16'h1234);
    bus_read(3'd5, 16'h0000, "count_cleared");
    rise_burst(65535);
    bus_read(3'd5, 16'hFFFF, "count_at_max");
    rise_burst(3);
    bus_read(3'd5, 16'hFFFF, "count_saturated");
    @(negedge clk); irq_in = 8'h01;
    @(posedge clk);
    bus_write(3'd5, 16'h0000);
    bus_read(3'd5, 16'h0000, "count_clear_wins");
    bus_read(3'd6, 16'h0000, "addr6_zero");
  endtask

  initial begin
    test_reset();
    test_edge_pulse();
    test_level();
    test_vector();
    test_set_wins();
    test_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
